// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared types and sizing helpers for the piso_serializer block.
//   - piso_state_e : FSM state (IDLE, SHIFT)
//   - cnt_width()  : beat counter width, clog2(WIDTH+1)
//   - beats()      : beats per word, WIDTH (+1 when PISO_PARITY_EN is defined)
// Optional build macro: PISO_PARITY_EN (appends one parity beat per word).
// -----------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BEATS = 1;
`else
  localparam int PARITY_BEATS = 0;
`endif

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int beats(input int width);
    return width + PARITY_BEATS;
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// -----------------------------------------------------------------------------
// piso_shift_core
// WIDTH-bit shift register with parallel load and a zero-filling shift toward
// the output end. Direction is fixed at elaboration by MSB_FIRST.
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  asynchronous active-low reset (register clears to 0)
//   load_i  in  load data_i this cycle (has priority over shift_i)
//   data_i  in  parallel word
//   shift_i in  shift one position toward the output end
//   bit_o   out bit currently at the output end
// -----------------------------------------------------------------------------
module piso_shift_core
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {sreg_q[WIDTH-2:0], 1'b0};
      assign bit_o   = sreg_q[WIDTH-1];
    end else begin : g_lsb_first
      assign shifted = {1'b0, sreg_q[WIDTH-1:1]};
      assign bit_o   = sreg_q[0];
    end
  endgenerate

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      sreg_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in/serial-out serializer. Accepts a WIDTH-bit word on a load
// handshake and emits it one bit per beat on a serial handshake, with a
// last-beat marker and bubble-free back-to-back loads.
// Optional build macro: PISO_PARITY_EN -- adds one parity beat per word
// (XOR of the word, inverted when PARITY_ODD=1) carrying ser_last.
// Ports:
//   clk        in  clock, rising edge
//   reset      in  asynchronous active-low reset
//   load_data  in  parallel word
//   load_valid in  producer offers load_data
//   load_ready out block accepts a word this cycle
//   ser_out    out current serial bit
//   ser_valid  out ser_out is valid
//   ser_ready  in  consumer takes the bit this cycle
//   ser_last   out current beat is the final beat of the word
//   busy       out a word is in flight (state SHIFT)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised, the offered data holds until it transfers.
// load_ready depends combinationally on ser_ready during the last beat so the
// next word can be taken in the same edge the last beat leaves.
// -----------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy
);

  localparam int            BEATS    = beats(WIDTH);
  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  piso_state_e   state_q;
  piso_state_e   state_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic in_shift;
  logic last_beat;
  logic xfer;
  logic load_en;
  logic shift_en;
  logic shift_bit;
  logic data_bit;

  assign in_shift   = (state_q == SHIFT);
  assign last_beat  = in_shift && (count_q == LAST_CNT);
  assign xfer       = in_shift && ser_ready;

  assign load_ready = !in_shift || (last_beat && ser_ready);
  assign ser_valid  = in_shift;
  assign busy       = in_shift;
  assign ser_last   = last_beat;
  // Gate with the state so the output reads 0 whenever no word is in flight.
  assign ser_out    = in_shift && data_bit;

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (load_en),
    .data_i  (load_data),
    .shift_i (shift_en),
    .bit_o   (shift_bit)
  );

`ifdef PISO_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (load_en) begin
      parity_q <= (^load_data) ^ PARITY_ODD;
    end
  end

  // The data beats occupy counts 0..WIDTH-1; count WIDTH is the parity beat.
  assign data_bit = (count_q == CW'(WIDTH)) ? parity_q : shift_bit;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign data_bit          = shift_bit;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          load_en = 1'b1;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (last_beat) begin
            // Count is cleared on the last beat either way, so it never
            // climbs past BEATS-1 and never wraps.
            count_d = '0;
            if (load_valid) begin
              load_en = 1'b1;
            end else begin
              shift_en = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            shift_en = 1'b1;
            count_d  = count_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Two serializers (MSB-first and LSB-first) share one stimulus stream; a queue
// model of the bits still owed per word predicts every output each cycle, and
// directed tests pin the collected streams against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] load_data;
  logic       load_valid;
  logic       ser_ready;

  logic m_load_ready, m_ser_out, m_ser_valid, m_ser_last, m_busy;
  logic l_load_ready, l_ser_out, l_ser_valid, l_ser_last, l_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: bits still to be emitted by each instance, head = current beat.
  bit exp_msb_q[$];
  bit exp_lsb_q[$];

  // Logs of what the DUTs actually transferred.
  logic [31:0] m_val, l_val, m_lastf, l_lastf;
  int          m_n, l_n;
  int          first_xfer_cyc, last_xfer_cyc;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_ODD(1'b0)) dut_msb (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (m_load_ready),
    .ser_out    (m_ser_out),
    .ser_valid  (m_ser_valid),
    .ser_ready  (ser_ready),
    .ser_last   (m_ser_last),
    .busy       (m_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_ODD(1'b1)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (l_load_ready),
    .ser_out    (l_ser_out),
    .ser_valid  (l_ser_valid),
    .ser_ready  (ser_ready),
    .ser_last   (l_ser_last),
    .busy       (l_busy)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checks
  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_inst(input string tag, input int size, input bit head,
                            input logic so, input logic sv, input logic sl,
                            input logic b, input logic lr);
    bit e_valid;
    e_valid = (size > 0);
    check_bit({tag, ".ser_valid"},  sv, e_valid);
    check_bit({tag, ".busy"},       b,  e_valid);
    check_bit({tag, ".ser_out"},    so, e_valid ? head : 1'b0);
    check_bit({tag, ".ser_last"},   sl, size == 1);
    check_bit({tag, ".load_ready"}, lr, !e_valid || (size == 1 && ser_ready));
  endtask

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    bit xfer, acc;
    cyc++;
    if (!reset) begin
      exp_msb_q.delete();
      exp_lsb_q.delete();
    end
    check_inst("msb", exp_msb_q.size(), exp_msb_q.size() > 0 ? exp_msb_q[0] : 1'b0,
               m_ser_out, m_ser_valid, m_ser_last, m_busy, m_load_ready);
    check_inst("lsb", exp_lsb_q.size(), exp_lsb_q.size() > 0 ? exp_lsb_q[0] : 1'b0,
               l_ser_out, l_ser_valid, l_ser_last, l_busy, l_load_ready);
    if (reset) begin
      if (m_ser_valid && ser_ready) begin
        if (m_n == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        m_val   = {m_val[30:0], m_ser_out};
        m_lastf = {m_lastf[30:0], m_ser_last};
        m_n++;
      end
      if (l_ser_valid && ser_ready) begin
        l_val   = {l_val[30:0], l_ser_out};
        l_lastf = {l_lastf[30:0], l_ser_last};
        l_n++;
      end
      // Advance the model to what the coming rising edge does.
      xfer = (exp_msb_q.size() > 0) && ser_ready;
      acc  = load_valid && ((exp_msb_q.size() == 0) || (exp_msb_q.size() == 1 && ser_ready));
      if (xfer) begin
        void'(exp_msb_q.pop_front());
        void'(exp_lsb_q.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < 8; i++) begin
          exp_msb_q.push_back(load_data[7 - i]);
          exp_lsb_q.push_back(load_data[i]);
        end
`ifdef PISO_PARITY_EN
        exp_msb_q.push_back(^load_data);
        exp_lsb_q.push_back(~(^load_data));
`endif
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic clear_logs();
    @(posedge clk);
    #1;
    m_val = '0; l_val = '0; m_lastf = '0; l_lastf = '0;
    m_n = 0; l_n = 0; first_xfer_cyc = 0; last_xfer_cyc = 0;
  endtask

  task automatic load_word(input logic [7:0] w, output int waited);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    load_data  = w;
    load_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      if (m_load_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL load_timeout actual=no_load_ready expected=load_ready");
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    check_bit("latency.ser_valid", m_ser_valid, 1'b1);
    check_bit("latency.msb_first_bit", m_ser_out, w[7]);
    check_bit("latency.lsb_first_bit", l_ser_out, w[0]);
    waited = n;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!m_busy && !l_busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int w;
    logic [3:0] pat;
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    ser_ready  = 1'b1;
    m_val = '0; l_val = '0; m_lastf = '0; l_lastf = '0;
    m_n = 0; l_n = 0; first_xfer_cyc = 0; last_xfer_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset.load_ready", m_load_ready, 1'b1);
    check_bit("reset.ser_valid",  m_ser_valid,  1'b0);
    check_bit("reset.ser_out",    m_ser_out,    1'b0);
    reset = 1'b1;

`ifndef PISO_PARITY_EN
    // A5, both bit orders, full-rate consumer
    clear_logs();
    load_word(8'hA5, w);
    check_word("t1.idle_accept_wait", w, 1);
    wait_idle();
    check_word("t1.msb_stream", m_val, 32'hA5);
    check_word("t1.lsb_stream", l_val, 32'hA5);
    check_word("t1.beats",      m_n,   8);
    check_word("t1.last_flags", m_lastf, 32'h01);
    check_bit("t1.busy_after",  m_busy, 1'b0);

    // 01: single one at the far end of the word
    clear_logs();
    load_word(8'h01, w);
    wait_idle();
    check_word("t1b.msb_stream", m_val, 32'h01);
    check_word("t1b.lsb_stream", l_val, 32'h80);

    // Back-to-back FF then 00, load_valid held high through the first word
    clear_logs();
    load_word(8'hFF, w);
    load_word(8'h00, w);
    check_word("t2.accept_on_beat8", w, 8);
    wait_idle();
    check_word("t2.msb_stream", m_val, 32'hFF00);
    check_word("t2.lsb_stream", l_val, 32'hFF00);
    check_word("t2.beats",      m_n,   16);
    check_word("t2.no_gap",     last_xfer_cyc - first_xfer_cyc, 15);
    check_word("t2.last_flags", m_lastf, 32'h0101);

    // Backpressure on 3C with ser_ready pattern 1,0,0,1 repeating
    clear_logs();
    load_word(8'h3C, w);
    pat = 4'b1001;
    for (int i = 0; i < 100 && m_busy; i++) begin
      ser_ready = pat[3 - (i % 4)];
      @(posedge clk);
      #1;
    end
    ser_ready = 1'b1;
    check_word("t3.msb_stream", m_val, 32'h3C);
    check_word("t3.lsb_stream", l_val, 32'h3C);
    check_word("t3.beats",      m_n,   8);
    check_word("t3.last_flags", m_lastf, 32'h01);

    // Reset after three beats of F0
    clear_logs();
    load_word(8'hF0, w);
    for (int i = 0; i < 50 && m_n < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check_word("t4.beats_before_reset", m_val, 32'h7);
    #2;
    reset = 1'b0;
    #1;
    check_bit("t4.async.ser_valid",  m_ser_valid,  1'b0);
    check_bit("t4.async.ser_out",    m_ser_out,    1'b0);
    check_bit("t4.async.ser_last",   m_ser_last,   1'b0);
    check_bit("t4.async.busy",       m_busy,       1'b0);
    check_bit("t4.async.load_ready", m_load_ready, 1'b1);
    check_bit("t4.async.lsb_busy",   l_busy,       1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    clear_logs();
    repeat (5) @(posedge clk);
    #1;
    check_word("t4.no_stale_beats", m_n, 0);
    check_bit("t4.release.load_ready", m_load_ready, 1'b1);
    load_word(8'h5A, w);
    wait_idle();
    check_word("t4.fresh_msb", m_val, 32'h5A);
    check_word("t4.fresh_lsb", l_val, 32'h5A);
`else
    // Parity: msb instance even parity, lsb instance odd parity
    clear_logs();
    load_word(8'h07, w);
    wait_idle();
    check_word("tp.beats",      m_n,   9);
    check_word("tp.msb_stream", m_val, 32'h00F);
    check_word("tp.lsb_stream", l_val, 32'h1C0);
    check_word("tp.last_flags", m_lastf, 32'h001);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out serializer; the successor to the fixed 4-bit PISO chain.
- Accepts a WIDTH-bit word over a valid/ready load handshake and emits it one bit per beat over a valid/ready serial handshake.
- Supports selectable bit order and a last-bit marker, and loads back-to-back without bubbles.
- Sits between a parallel producer (FSM or register file) and a serial link or bit-bang transmitter.

Parameters:
- WIDTH, 8, word width in bits; legal range 2 to 64.
- MSB_FIRST, 1, 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.
- PARITY_ODD, 0, parity sense for the optional parity beat; 0 = even, 1 = odd. Ignored when the parity feature is compiled out.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; assertion takes effect immediately, release is synchronous to clk.
- load_data  in  WIDTH  parallel word to serialise.
- load_valid  in  1  producer has a word on load_data.
- load_ready  out  1  block accepts a word this cycle.
- ser_out  out  1  current serial bit.
- ser_valid  out  1  ser_out holds a valid bit.
- ser_ready  in  1  consumer takes the bit this cycle.
- ser_last  out  1  current bit is the final beat of the word.
- busy  out  1  a word is in flight (state SHIFT).

Behaviour:
- Reset values (reset low): state IDLE, shift register 0, count 0, ser_out 0, ser_valid 0, ser_last 0, busy 0. load_ready evaluates to 1 because state is IDLE.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready = 1.
  - On load_valid, latch load_data into the shift register, clear count, go to SHIFT.
- SHIFT:
  - ser_valid = 1 and busy = 1.
  - ser_out = sreg[WIDTH-1] when MSB_FIRST=1, else sreg[0].
  - A beat transfers when ser_valid and ser_ready are both high. On a transfer, shift the register toward the output end, zero-fill, and increment count.
  - With ser_ready low, ser_out and ser_last hold stable for as long as it stays low.
- Latency: the first bit is valid in the cycle after load acceptance.
- Beats per word: WIDTH. ser_last = 1 exactly when count == WIDTH-1 (or on the parity beat when that feature is enabled).
- load_ready in SHIFT is 1 only in the last-beat cycle, and only when ser_ready is high. It is the only combinational input-to-output path.
- Final beat transfers and load_valid is high in the same cycle: load the new word, clear count, stay in SHIFT. No idle cycle between words.
- Final beat transfers and load_valid is low: return to IDLE; ser_valid drops on the next cycle.
- load_valid asserted in SHIFT outside the last-beat cycle: ignored; the producer holds its word until accepted.
- Count width is clog2(WIDTH+1) and never wraps past the beat total.
- Reset asserted mid-word: the word is discarded immediately, all outputs return to reset values, and no partial beats resume after release.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - One extra beat follows the data beats, carrying XOR-reduce(word), inverted when PARITY_ODD=1.
  - Parity is computed at load time and stored in a 1-bit register.
  - Beats per word become WIDTH+1; ser_last moves to the parity beat.
- Undefined: exactly WIDTH beats, no parity logic or register, and PARITY_ODD is ignored.

Decomposition:
- Package piso_pkg holds:
  - the state enum (IDLE, SHIFT);
  - the function for count width, clog2(WIDTH+1);
  - the constant BEATS = WIDTH, plus 1 when PISO_PARITY_EN is defined.
- One sub-module: piso_shift_core. It holds the WIDTH-bit register with load, shift enable and direction. The top level owns the FSM, the counter and both handshakes.

Test Plan:
- Load 8'hA5 with MSB_FIRST=1 and ser_ready held at 1 -> ser_out sequence 1,0,1,0,0,1,0,1 on cycles 1 to 8 after load; ser_last only on cycle 8; busy drops after it.
- Load 8'hA5 with MSB_FIRST=0 -> sequence 1,0,1,0,0,1,0,1 (bit 0 first); check with 8'h01 -> 1 followed by seven 0s.
- Back-to-back: load 8'hFF, then hold load_valid with 8'h00 -> load_ready pulses in the cycle of the 8th beat; eight 1s followed directly by eight 0s with no gap in ser_valid.
- Backpressure: toggle ser_ready 1,0,0,1,... while sending 8'h3C -> ser_out and ser_last stable while stalled; exactly 8 transfers; the stream equals 0,0,1,1,1,1,0,0.
- Reset mid-word: assert reset after 3 beats of 8'hF0 -> outputs go to reset values with no clock edge; after release, load_ready = 1 and no stale beats appear.
- With PISO_PARITY_EN defined and PARITY_ODD=0, load 8'h07 -> 9 beats, the 9th equals 1 with ser_last set. With PARITY_ODD=1 the 9th beat equals 0.
